// File: rtl/common.sv
// Shared types for the core pipeline: register/bus typedefs, access sizes and the
// memory-stage state enum, plus small size helpers used by the stage and its aligner.
package common;

  typedef logic [63:0] u64;
  typedef logic [4:0]  creg_addr_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic       valid;
    u64         addr;
    msize_t     size;
    logic [7:0] strobe;
    u64         data;
  } dbus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u64   data;
  } dbus_resp_t;

  // Instruction held by the memory stage while its bus access is outstanding.
  typedef struct packed {
    u64         pc;
    logic       is_load;
    logic       is_store;
    msize_t     msize;
    logic       is_unsigned;
    u64         addr;
    u64         wdata;
    logic       wen;
    creg_addr_t dst;
  } mem_entry_t;

  function automatic logic [7:0] size_mask(msize_t s);
    case (s)
      MSIZE1:  return 8'h01;
      MSIZE2:  return 8'h03;
      MSIZE4:  return 8'h0f;
      default: return 8'hff;
    endcase
  endfunction

  function automatic logic is_aligned(logic [2:0] lo, msize_t s);
    case (s)
      MSIZE1:  return 1'b1;
      MSIZE2:  return lo[0] == 1'b0;
      MSIZE4:  return lo[1:0] == 2'b00;
      default: return lo == 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Bundle of the memory stage's upstream handshake, data-bus and writeback signals.
// master: execute side plus memory model; slave: the memory stage itself.
interface mem_access_if;
  import common::*;

  logic       in_valid;
  logic       in_ready;
  u64         in_pc;
  logic       in_is_load;
  logic       in_is_store;
  msize_t     in_msize;
  logic       in_unsigned;
  u64         in_addr;
  u64         in_wdata;
  u64         in_alu;
  logic       in_wen;
  creg_addr_t in_dst;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       wb_valid;
  logic       wb_wen;
  creg_addr_t wb_wa;
  u64         wb_wd;
  u64         wb_pc;
  logic       wb_misalign;

  modport master (
    output in_valid, in_pc, in_is_load, in_is_store, in_msize, in_unsigned,
           in_addr, in_wdata, in_alu, in_wen, in_dst, dresp,
    input  in_ready, dreq, wb_valid, wb_wen, wb_wa, wb_wd, wb_pc, wb_misalign
  );

  modport slave (
    input  in_valid, in_pc, in_is_load, in_is_store, in_msize, in_unsigned,
           in_addr, in_wdata, in_alu, in_wen, in_dst, dresp,
    output in_ready, dreq, wb_valid, wb_wen, wb_wa, wb_wd, wb_pc, wb_misalign
  );

endinterface

// File: rtl/mem_align.sv
// Combinational byte-lane aligner: store strobe/data placement within the 64-bit bus
// word, and load extraction with sign/zero extension.
module mem_align
  import common::*;
(
  input  logic [2:0] offset_i,
  input  msize_t     size_i,
  input  logic       unsigned_i,
  input  u64         wdata_i,
  input  u64         rdata_i,
  output logic [7:0] strobe_o,
  output u64         wdata_o,
  output u64         rdata_o
);

  u64 rdata_sh;

  always_comb begin
    strobe_o = size_mask(size_i) << offset_i;
    wdata_o  = wdata_i << {offset_i, 3'b000};
    rdata_sh = rdata_i >> {offset_i, 3'b000};
    case (size_i)
      MSIZE1:  rdata_o = unsigned_i ? {56'd0, rdata_sh[7:0]}
                                    : {{56{rdata_sh[7]}}, rdata_sh[7:0]};
      MSIZE2:  rdata_o = unsigned_i ? {48'd0, rdata_sh[15:0]}
                                    : {{48{rdata_sh[15]}}, rdata_sh[15:0]};
      MSIZE4:  rdata_o = unsigned_i ? {32'd0, rdata_sh[31:0]}
                                    : {{32{rdata_sh[31]}}, rdata_sh[31:0]};
      default: rdata_o = rdata_sh;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: retires ALU results directly, runs loads/stores over the data bus.
// Define MEM_MISALIGN_CHECK_EN to retire misaligned accesses without touching the bus.
module mem_access
  import common::*;
(
  input logic           clk,
  input logic           reset,
  mem_access_if.slave   bus
);

  mem_state_t state_q, state_d;
  mem_entry_t entry_q, entry_d;
  logic       wb_valid_q, wb_valid_d;
  logic       wb_wen_q, wb_wen_d;
  creg_addr_t wb_wa_q, wb_wa_d;
  u64         wb_wd_q, wb_wd_d;
  u64         wb_pc_q, wb_pc_d;
  logic       wb_misalign_q, wb_misalign_d;

  logic       accept, in_is_mem, in_misalign;
  logic [7:0] al_strobe;
  u64         al_wdata, al_rdata;

  logic unused_addr_ok;
  assign unused_addr_ok = bus.dresp.addr_ok;

  assign accept    = bus.in_valid & (state_q == IDLE);
  assign in_is_mem = bus.in_is_load | bus.in_is_store;
`ifdef MEM_MISALIGN_CHECK_EN
  assign in_misalign = in_is_mem & ~is_aligned(bus.in_addr[2:0], bus.in_msize);
`else
  assign in_misalign = 1'b0;
`endif

  mem_align u_align (
    .offset_i   (entry_q.addr[2:0]),
    .size_i     (entry_q.msize),
    .unsigned_i (entry_q.is_unsigned),
    .wdata_i    (entry_q.wdata),
    .rdata_i    (bus.dresp.data),
    .strobe_o   (al_strobe),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata)
  );

  always_comb begin
    state_d       = state_q;
    entry_d       = entry_q;
    wb_valid_d    = 1'b0;
    wb_wen_d      = wb_wen_q;
    wb_wa_d       = wb_wa_q;
    wb_wd_d       = wb_wd_q;
    wb_pc_d       = wb_pc_q;
    wb_misalign_d = wb_misalign_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          entry_d = '{pc: bus.in_pc, is_load: bus.in_is_load, is_store: bus.in_is_store,
                      msize: bus.in_msize, is_unsigned: bus.in_unsigned, addr: bus.in_addr,
                      wdata: bus.in_wdata, wen: bus.in_wen, dst: bus.in_dst};
          if (in_is_mem && !in_misalign) begin
            state_d = BUSY;
          end else begin
            // ALU ops and rejected misaligned accesses retire straight from the inputs.
            wb_valid_d    = 1'b1;
            wb_wa_d       = bus.in_dst;
            wb_pc_d       = bus.in_pc;
            wb_wd_d       = in_misalign ? '0 : bus.in_alu;
            wb_wen_d      = bus.in_wen & ~in_misalign & (bus.in_dst != '0);
            wb_misalign_d = in_misalign;
          end
        end
      end
      BUSY: begin
        if (bus.dresp.data_ok) begin
          state_d       = IDLE;
          wb_valid_d    = 1'b1;
          wb_wa_d       = entry_q.dst;
          wb_pc_d       = entry_q.pc;
          wb_wd_d       = entry_q.is_load ? al_rdata : '0;
          wb_wen_d      = entry_q.is_load & entry_q.wen & (entry_q.dst != '0);
          wb_misalign_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      entry_q       <= '0;
      wb_valid_q    <= 1'b0;
      wb_wen_q      <= 1'b0;
      wb_wa_q       <= '0;
      wb_wd_q       <= '0;
      wb_pc_q       <= '0;
      wb_misalign_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      entry_q       <= entry_d;
      wb_valid_q    <= wb_valid_d;
      wb_wen_q      <= wb_wen_d;
      wb_wa_q       <= wb_wa_d;
      wb_wd_q       <= wb_wd_d;
      wb_pc_q       <= wb_pc_d;
      wb_misalign_q <= wb_misalign_d;
    end
  end

  always_comb begin
    bus.in_ready       = (state_q == IDLE);
    bus.dreq.valid     = (state_q == BUSY);
    bus.dreq.addr      = entry_q.addr;
    bus.dreq.size      = entry_q.msize;
    bus.dreq.strobe    = ((state_q == BUSY) && entry_q.is_store) ? al_strobe : 8'h00;
    bus.dreq.data      = al_wdata;
    bus.wb_valid       = wb_valid_q;
    bus.wb_wen         = wb_wen_q;
    bus.wb_wa          = wb_wa_q;
    bus.wb_wd          = wb_wd_q;
    bus.wb_pc          = wb_pc_q;
    bus.wb_misalign    = wb_misalign_q;
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed cases plus random ALU/load/store traffic checked
// against a byte-arithmetic reference model.
module tb_mem_access;
  import common::*;

`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit MisEn = 1'b1;
`else
  localparam bit MisEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_access_if bus ();

  mem_access dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input u64 obs, input u64 exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  function automatic u64 ref_load(input u64 data, input int off, input int n, input bit uns);
    u64 v;
    int nb;
    v  = data >> (8 * off);
    nb = 8 * n;
    if (nb < 64) begin
      v = v << (64 - nb);
      v = uns ? (v >> (64 - nb)) : u64'($signed(v) >>> (64 - nb));
    end
    return v;
  endfunction

  function automatic logic [7:0] ref_strobe(input int off, input int n);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) if (i >= off && i < off + n) s[i] = 1'b1;
    return s;
  endfunction

  // kind: 0 = ALU, 1 = load, 2 = store. Called just after a rising edge with the stage idle.
  task automatic do_op(input string tag, input int kind, input int sz, input bit uns,
                       input u64 addr, input u64 wdata, input u64 alu, input bit wen,
                       input creg_addr_t dst, input u64 pc, input u64 rdata,
                       input int waits);
    int n, off;
    bit mis, is_mem;
    n      = 1 << sz;
    off    = int'(addr[2:0]);
    is_mem = (kind != 0);
    mis    = is_mem && MisEn && ((addr % u64'(n)) != 0);
    chk({tag, ".in_ready_pre"}, u64'(bus.in_ready), 64'd1);
    bus.in_valid    = 1'b1;
    bus.in_is_load  = (kind == 1);
    bus.in_is_store = (kind == 2);
    bus.in_msize    = msize_t'(sz);
    bus.in_unsigned = uns;
    bus.in_addr     = addr;
    bus.in_wdata    = wdata;
    bus.in_alu      = alu;
    bus.in_wen      = wen;
    bus.in_dst      = dst;
    bus.in_pc       = pc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (!is_mem || mis) begin
      chk({tag, ".wb_valid"}, u64'(bus.wb_valid), 64'd1);
      chk({tag, ".wb_misalign"}, u64'(bus.wb_misalign), u64'(mis));
      chk({tag, ".wb_wen"}, u64'(bus.wb_wen), u64'(!mis && wen && dst != 0));
      chk({tag, ".wb_wa"}, u64'(bus.wb_wa), u64'(dst));
      chk({tag, ".wb_pc"}, bus.wb_pc, pc);
      if (!mis) chk({tag, ".wb_wd"}, bus.wb_wd, alu);
      chk({tag, ".dreq_valid"}, u64'(bus.dreq.valid), 64'd0);
      chk({tag, ".in_ready"}, u64'(bus.in_ready), 64'd1);
    end else begin
      chk({tag, ".in_ready_busy"}, u64'(bus.in_ready), 64'd0);
      chk({tag, ".dreq_addr"}, bus.dreq.addr, addr);
      chk({tag, ".dreq_size"}, u64'(bus.dreq.size), u64'(sz));
      chk({tag, ".dreq_strobe"}, u64'(bus.dreq.strobe),
          (kind == 2) ? u64'(ref_strobe(off, n)) : 64'd0);
      if (kind == 2) chk({tag, ".dreq_data"}, bus.dreq.data, wdata << (8 * off));
      for (int w = 0; w <= waits; w++) begin
        bus.dresp.data_ok = (w == waits);
        bus.dresp.data    = (w == waits) ? rdata : {$urandom, $urandom};
        chk({tag, ".dreq_valid_held"}, u64'(bus.dreq.valid), 64'd1);
        chk({tag, ".wb_idle"}, u64'(bus.wb_valid), 64'd0);
        @(posedge clk); #1;
      end
      bus.dresp.data_ok = 1'b0;
      chk({tag, ".wb_valid"}, u64'(bus.wb_valid), 64'd1);
      chk({tag, ".dreq_drop"}, u64'(bus.dreq.valid), 64'd0);
      chk({tag, ".wb_wen"}, u64'(bus.wb_wen), u64'((kind == 1) && wen && dst != 0));
      chk({tag, ".wb_wa"}, u64'(bus.wb_wa), u64'(dst));
      chk({tag, ".wb_pc"}, bus.wb_pc, pc);
      chk({tag, ".wb_misalign"}, u64'(bus.wb_misalign), 64'd0);
      if (kind == 1) chk({tag, ".wb_wd"}, bus.wb_wd, ref_load(rdata, off, n, uns));
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_is_load  = 1'b0;
    bus.in_is_store = 1'b0;
    bus.in_msize    = MSIZE1;
    bus.in_unsigned = 1'b0;
    bus.in_addr     = '0;
    bus.in_wdata    = '0;
    bus.in_alu      = '0;
    bus.in_wen      = 1'b0;
    bus.in_dst      = '0;
    bus.in_pc       = '0;
    bus.dresp       = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst.in_ready", u64'(bus.in_ready), 64'd1);
    chk("rst.dreq_valid", u64'(bus.dreq.valid), 64'd0);
    chk("rst.dreq_strobe", u64'(bus.dreq.strobe), 64'd0);
    chk("rst.wb_valid", u64'(bus.wb_valid), 64'd0);
    chk("rst.wb_wen", u64'(bus.wb_wen), 64'd0);
    chk("rst.wb_misalign", u64'(bus.wb_misalign), 64'd0);
    chk("rst.wb_wd", bus.wb_wd, 64'd0);

    do_op("alu", 0, 0, 0, 64'h0, 64'h0, 64'h1234, 1, 5'd5, 64'h100, 64'h0, 0);
    do_op("alu2", 0, 0, 0, 64'h0, 64'h0, 64'hdead_beef, 1, 5'd7, 64'h104, 64'h0, 0);
    do_op("lb", 1, 0, 0, 64'h1003, 64'h0, 64'h0, 1, 5'd9, 64'h108,
          64'h00000000_80000000, 2);
    chk("lb.wd_const", bus.wb_wd, 64'hFFFFFFFF_FFFFFF80);
    do_op("sh", 2, 1, 0, 64'h2006, 64'hBEEF, 64'h0, 1, 5'd3, 64'h10c, 64'h0, 0);
    do_op("ld_x0", 1, 3, 0, 64'h3000, 64'h0, 64'h0, 1, 5'd0, 64'h110,
          64'h0123_4567_89ab_cdef, 1);
    @(posedge clk); #1;
    chk("pulse.wb_valid", u64'(bus.wb_valid), 64'd0);

    // Stray data_ok while idle must not retire anything.
    bus.dresp.data_ok = 1'b1;
    @(posedge clk); #1;
    bus.dresp.data_ok = 1'b0;
    chk("idle_dok.wb_valid", u64'(bus.wb_valid), 64'd0);
    chk("idle_dok.in_ready", u64'(bus.in_ready), 64'd1);

    // Reset while BUSY abandons the access.
    bus.in_valid    = 1'b1;
    bus.in_is_load  = 1'b1;
    bus.in_is_store = 1'b0;
    bus.in_msize    = MSIZE4;
    bus.in_addr     = 64'h4000;
    bus.in_wen      = 1'b1;
    bus.in_dst      = 5'd4;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("rstbusy.dreq_valid_pre", u64'(bus.dreq.valid), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstbusy.dreq_valid", u64'(bus.dreq.valid), 64'd0);
    chk("rstbusy.in_ready", u64'(bus.in_ready), 64'd1);
    chk("rstbusy.wb_valid", u64'(bus.wb_valid), 64'd0);
    bus.dresp.data_ok = 1'b1;
    @(posedge clk); #1;
    bus.dresp.data_ok = 1'b0;
    chk("rstbusy.wb_valid2", u64'(bus.wb_valid), 64'd0);

    if (MisEn) begin
      do_op("mis_lw", 1, 2, 0, 64'h1002, 64'h0, 64'h0, 1, 5'd6, 64'h200, 64'h0, 0);
    end

    for (int i = 0; i < 80; i++) begin
      int kind, sz;
      u64 addr;
      kind = int'($urandom_range(0, 2));
      sz   = int'($urandom_range(0, 3));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr = addr & ~u64'((1 << sz) - 1);
      do_op($sformatf("rnd%0d", i), kind, sz, 1'($urandom), addr, {$urandom, $urandom},
            {$urandom, $urandom}, 1'($urandom), creg_addr_t'($urandom_range(0, 31)),
            {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
